// File: rtl/osnt_sume_byte_order_pkg.sv
// Shared definitions for the OSNT SUME byte-order converter: mode encodings,
// FSM state type, counter width and the byte permutation index function.
`timescale 1ns/1ps
package osnt_sume_byte_order_pkg;

  typedef enum logic [1:0] {
    MODE_PASS    = 2'd0,  // bytes unchanged
    MODE_GRP_REV = 2'd1,  // reverse bytes inside each swap group
    MODE_ORD_REV = 2'd2,  // reverse order of groups, bytes inside kept
    MODE_RSVD    = 2'd3   // reserved, replaced by the default mode
  } mode_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } state_t;

  localparam int CNT_W = 32;

  // Source byte index feeding output byte i for a given mode, group size g
  // and bus width in bytes.
  function automatic int src_byte(input logic [1:0] mode, input int i,
                                  input int g, input int data_bytes);
    int grp;
    int k;
    int ng;
    grp = i / g;
    k   = i % g;
    ng  = data_bytes / g;
    case (mode)
      MODE_GRP_REV: return grp * g + (g - 1 - k);
      MODE_ORD_REV: return (ng - 1 - grp) * g + k;
      default:      return i;
    endcase
  endfunction

endpackage

// File: rtl/osnt_sume_axis_skid_buffer.sv
// Generic two-entry AXI4-Stream register slice (output register + skid entry).
// Handshake: a transfer happens on a clock edge where valid and ready are both
// high; valid never drops and payload never changes while waiting for ready.
// in_ready is a register (inverse of skid occupancy) so there is no
// combinational path from out_ready back to in_ready.
`timescale 1ns/1ps
module osnt_sume_axis_skid_buffer #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [PW-1:0] in_payload,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [PW-1:0] out_payload,
  output logic          out_valid,
  input  logic          out_ready
);

  logic [PW-1:0] skid_payload;
  logic          skid_valid;
  logic          accept;
  logic          out_free;

  assign accept   = in_valid && in_ready;
  assign out_free = !out_valid || out_ready;

  // Output register refills from the skid entry first, then from the input;
  // an input beat arriving while the output is stalled parks in the skid entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_payload  <= '0;
      out_valid    <= 1'b0;
      skid_payload <= '0;
      skid_valid   <= 1'b0;
      in_ready     <= 1'b0;
    end else begin
      if (out_free) begin
        in_ready <= 1'b1;
        if (skid_valid) begin
          out_payload <= skid_payload;
          out_valid   <= 1'b1;
          skid_valid  <= 1'b0;
        end else if (accept) begin
          out_payload <= in_payload;
          out_valid   <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (accept) begin
        skid_payload <= in_payload;
        skid_valid   <= 1'b1;
        in_ready     <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/osnt_sume_byte_order_converter.sv
// AXI4-Stream byte-order converter with selectable swap granularity and a
// per-packet latched mode. Data is permuted on the input side and registered
// through a skid buffer (1 cycle latency, 1 beat/cycle under backpressure).
// Optional statistics counters are enabled with the BYTE_ORDER_STATS_EN macro.
`timescale 1ns/1ps
module osnt_sume_byte_order_converter
  import osnt_sume_byte_order_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_SWAP_GROUP_BYTES = 8,
  parameter int C_DEFAULT_MODE     = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [1:0]                      cfg_mode,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tlast,
  output logic                            s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,
  output logic [1:0]                      active_mode,
  output logic                            fsm_state
`ifdef BYTE_ORDER_STATS_EN
  ,
  input  logic                            stat_clear,
  output logic [CNT_W-1:0]                stat_pkts,
  output logic [CNT_W-1:0]                stat_beats,
  output logic [CNT_W-1:0]                stat_keep_err
`endif
);

  localparam int DATA_BYTES = C_AXIS_DATA_WIDTH / 8;
  localparam int G          = C_SWAP_GROUP_BYTES;
  localparam int PW         = C_AXIS_DATA_WIDTH + DATA_BYTES + C_AXIS_TUSER_WIDTH + 1;
  localparam logic [1:0] DEFAULT_MODE = 2'(C_DEFAULT_MODE);

  if ((C_AXIS_DATA_WIDTH % 8) != 0 || G < 1 || (G & (G - 1)) != 0 ||
      (DATA_BYTES % G) != 0 || C_DEFAULT_MODE < 0 || C_DEFAULT_MODE > 2) begin : g_bad_cfg
    $error("osnt_sume_byte_order_converter: illegal parameter combination");
  end

  state_t state;
  state_t state_next;
  logic   accept;
  logic [1:0] cfg_eff;
  logic [1:0] beat_mode;

  logic [C_AXIS_DATA_WIDTH-1:0] data_grp;
  logic [C_AXIS_DATA_WIDTH-1:0] data_ord;
  logic [DATA_BYTES-1:0]        keep_grp;
  logic [DATA_BYTES-1:0]        keep_ord;
  logic [C_AXIS_DATA_WIDTH-1:0] conv_data;
  logic [DATA_BYTES-1:0]        conv_keep;
  logic [PW-1:0]                in_payload;
  logic [PW-1:0]                out_payload;

  assign accept    = s_axis_tvalid && s_axis_tready;
  assign cfg_eff   = (cfg_mode == MODE_RSVD) ? DEFAULT_MODE : cfg_mode;
  // The first beat of a packet uses the live configuration, later beats the latched one.
  assign beat_mode = (state == ST_IDLE) ? cfg_eff : active_mode;
  assign fsm_state = state;

  // Fixed wiring for the two non-trivial permutations; keep follows data.
  for (genvar i = 0; i < DATA_BYTES; i++) begin : g_perm
    localparam int SG = src_byte(MODE_GRP_REV, i, G, DATA_BYTES);
    localparam int SO = src_byte(MODE_ORD_REV, i, G, DATA_BYTES);
    assign data_grp[8*i +: 8] = s_axis_tdata[8*SG +: 8];
    assign data_ord[8*i +: 8] = s_axis_tdata[8*SO +: 8];
    assign keep_grp[i]        = s_axis_tkeep[SG];
    assign keep_ord[i]        = s_axis_tkeep[SO];
  end

  // Select the permutation for the beat being presented.
  always_comb begin
    conv_data = s_axis_tdata;
    conv_keep = s_axis_tkeep;
    case (beat_mode)
      MODE_GRP_REV: begin
        conv_data = data_grp;
        conv_keep = keep_grp;
      end
      MODE_ORD_REV: begin
        conv_data = data_ord;
        conv_keep = keep_ord;
      end
      default: ;
    endcase
  end

  // Packet-tracking state register and latched mode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      active_mode <= DEFAULT_MODE;
    end else begin
      state <= state_next;
      if (state == ST_IDLE && accept) active_mode <= cfg_eff;
    end
  end

  // Next-state: a non-last first beat opens a packet, a last beat closes it.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (accept && !s_axis_tlast) state_next = ST_IN_PKT;
      ST_IN_PKT: if (accept && s_axis_tlast)  state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  assign in_payload = {conv_data, conv_keep, s_axis_tuser, s_axis_tlast};

  osnt_sume_axis_skid_buffer #(
    .PW (PW)
  ) u_skid (
    .clk         (clk),
    .reset       (reset),
    .in_payload  (in_payload),
    .in_valid    (s_axis_tvalid),
    .in_ready    (s_axis_tready),
    .out_payload (out_payload),
    .out_valid   (m_axis_tvalid),
    .out_ready   (m_axis_tready)
  );

  assign {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} = out_payload;

`ifdef BYTE_ORDER_STATS_EN
  logic emit;
  assign emit = m_axis_tvalid && m_axis_tready;

  // Saturating statistics counters; a clear request overrides any increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_pkts     <= '0;
      stat_beats    <= '0;
      stat_keep_err <= '0;
    end else if (stat_clear) begin
      stat_pkts     <= '0;
      stat_beats    <= '0;
      stat_keep_err <= '0;
    end else begin
      if (emit && m_axis_tlast && stat_pkts != '1)  stat_pkts  <= stat_pkts + 1'b1;
      if (emit && stat_beats != '1)                 stat_beats <= stat_beats + 1'b1;
      if (accept && !s_axis_tlast && s_axis_tkeep != {DATA_BYTES{1'b1}} &&
          stat_keep_err != '1)
        stat_keep_err <= stat_keep_err + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_osnt_sume_byte_order_converter.sv
// Self-checking bench for osnt_sume_byte_order_converter (default parameters).
// Directed vector table, hand-written packet/reset sequences, and a randomized
// stream scored against a queue-based reference model.
`timescale 1ns/1ps
module tb_osnt_sume_byte_order_converter;

  localparam int W        = 256;
  localparam int U        = 128;
  localparam int G        = 8;
  localparam int DB       = W / 8;
  localparam int EW       = W + DB + U + 1;
  localparam int DEF_MODE = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    cfg_mode = 2'd0;
  logic [W-1:0]  s_axis_tdata = '0;
  logic [DB-1:0] s_axis_tkeep = '0;
  logic [U-1:0]  s_axis_tuser = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  logic [W-1:0]  m_axis_tdata;
  logic [DB-1:0] m_axis_tkeep;
  logic [U-1:0]  m_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready = 1'b1;
  logic [1:0]    active_mode;
  logic          fsm_state;
`ifdef BYTE_ORDER_STATS_EN
  logic          stat_clear = 1'b0;
  logic [31:0]   stat_pkts;
  logic [31:0]   stat_beats;
  logic [31:0]   stat_keep_err;
`endif

  osnt_sume_byte_order_converter dut (
    .clk           (clk),
    .reset         (reset),
    .cfg_mode      (cfg_mode),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .active_mode   (active_mode),
    .fsm_state     (fsm_state)
`ifdef BYTE_ORDER_STATS_EN
    ,
    .stat_clear    (stat_clear),
    .stat_pkts     (stat_pkts),
    .stat_beats    (stat_beats),
    .stat_keep_err (stat_keep_err)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  logic [EW-1:0] exp_q[$];
  bit            mdl_in_pkt = 1'b0;
  logic [1:0]    mdl_mode = 2'(DEF_MODE);
  bit            rnd_ready = 1'b0;
  bit            last_acc = 1'b0;

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [1:0] eff_mode(input logic [1:0] m);
    return (m == 2'd3) ? 2'(DEF_MODE) : m;
  endfunction

  // Output byte i takes source byte: mode1 flips the low index bits inside
  // a power-of-two group; mode2 mirrors the group number, keeping the offset.
  function automatic logic [EW-1:0] ref_beat(input logic [1:0] mode, input logic [W-1:0] d,
                                             input logic [DB-1:0] k, input logic [U-1:0] u,
                                             input logic l);
    logic [W-1:0]  od;
    logic [DB-1:0] ok;
    int src;
    for (int i = 0; i < DB; i++) begin
      case (mode)
        2'd1:    src = i ^ (G - 1);
        2'd2:    src = (DB - G) - (i - (i % G)) + (i % G);
        default: src = i;
      endcase
      od[8*i +: 8] = d[8*src +: 8];
      ok[i]        = k[src];
    end
    return {od, ok, u, l};
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    for (int i = 0; i < W / 32; i++) w[32*i +: 32] = $urandom;
    return w;
  endfunction

  function automatic logic [U-1:0] rand_user();
    logic [U-1:0] w;
    for (int i = 0; i < U / 32; i++) w[32*i +: 32] = $urandom;
    return w;
  endfunction

  // One clock of scored operation: handshakes are evaluated on the stable
  // values before the edge, stall stability is checked after it.
  task automatic cycle();
    logic acc;
    logic emit;
    logic stall;
    logic [EW-1:0] held;
    logic [EW-1:0] got;
    acc   = s_axis_tvalid && s_axis_tready;
    emit  = m_axis_tvalid && m_axis_tready;
    stall = m_axis_tvalid && !m_axis_tready;
    held  = {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast};
    if (acc) begin
      if (!mdl_in_pkt) mdl_mode = eff_mode(cfg_mode);
      exp_q.push_back(ref_beat(mdl_mode, s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast));
      mdl_in_pkt = !s_axis_tlast;
    end
    if (emit) begin
      if (exp_q.size() == 0) check("unexpected_beat", held, '0);
      else begin
        got = exp_q.pop_front();
        check("beat", held, got);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (stall) begin
      check("stall_valid", EW'(m_axis_tvalid), EW'(1));
      check("stall_hold", {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast}, held);
    end
    last_acc = acc;
    if (rnd_ready) m_axis_tready = 1'($urandom_range(0, 1));
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [W-1:0] d, input logic [DB-1:0] k, input logic l);
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tuser  = rand_user();
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    last_acc      = 1'b0;
    for (int n = 0; n < 200; n++) begin
      cycle();
      if (last_acc) break;
    end
    check("accept_timeout", EW'(last_acc), EW'(1));
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic drain();
    s_axis_tvalid = 1'b0;
    for (int n = 0; n < 1000 && exp_q.size() > 0; n++) cycle();
    idle(2);
    check("drain_empty", EW'(exp_q.size()), EW'(0));
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [1:0]    mode;
    logic [W-1:0]  d;
    logic [DB-1:0] k;
    logic [W-1:0]  exp_d;
    logic [DB-1:0] exp_k;
    logic [1:0]    exp_mode;
  } vec_t;

  vec_t vecs[6];

  localparam logic [W-1:0] V_IN  = 256'h1F1E1D1C1B1A1918_1716151413121110_0F0E0D0C0B0A0908_0706050403020100;
  localparam logic [W-1:0] V_M1  = 256'h18191A1B1C1D1E1F_1011121314151617_08090A0B0C0D0E0F_0001020304050607;
  localparam logic [W-1:0] V_M2  = 256'h0706050403020100_0F0E0D0C0B0A0908_1716151413121110_1F1E1D1C1B1A1918;

  initial begin
    logic [U-1:0] u;
    int start;
    int plen;

    vecs[0] = '{2'd1, V_IN, 32'hFFFFFFFF, V_M1, 32'hFFFFFFFF, 2'd1};
    vecs[1] = '{2'd2, V_IN, 32'h000000FF, V_M2, 32'hFF000000, 2'd2};
    vecs[2] = '{2'd0, V_IN, 32'h0000F00F, V_IN, 32'h0000F00F, 2'd0};
    vecs[3] = '{2'd3, V_IN, 32'hFFFFFFFF, V_M1, 32'hFFFFFFFF, 2'd1};
    vecs[4] = '{2'd1, V_IN, 32'h00000003, V_M1, 32'h000000C0, 2'd1};
    vecs[5] = '{2'd2, V_IN, 32'h0000F00F, V_M2, 32'h0FF00000, 2'd2};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", EW'(m_axis_tvalid), EW'(0));
    check("rst_s_ready", EW'(s_axis_tready), EW'(0));
    check("rst_active_mode", EW'(active_mode), EW'(DEF_MODE));
    check("rst_m_data", EW'(m_axis_tdata), EW'(0));
    check("rst_fsm", EW'(fsm_state), EW'(0));
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_rst", EW'(s_axis_tready), EW'(1));

    // Table: single-beat packets, 1 cycle latency
    m_axis_tready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      u = rand_user();
      cfg_mode      = vecs[v].mode;
      s_axis_tdata  = vecs[v].d;
      s_axis_tkeep  = vecs[v].k;
      s_axis_tuser  = u;
      s_axis_tlast  = 1'b1;
      s_axis_tvalid = 1'b1;
      @(posedge clk);
      #1;
      s_axis_tvalid = 1'b0;
      check("vec_latency_valid", EW'(m_axis_tvalid), EW'(1));
      check("vec_data", EW'(m_axis_tdata), EW'(vecs[v].exp_d));
      check("vec_keep", EW'(m_axis_tkeep), EW'(vecs[v].exp_k));
      check("vec_user", EW'(m_axis_tuser), EW'(u));
      check("vec_last", EW'(m_axis_tlast), EW'(1));
      check("vec_active_mode", EW'(active_mode), EW'(vecs[v].exp_mode));
      check("vec_fsm_idle", EW'(fsm_state), EW'(0));
      @(posedge clk);
      #1;
      check("vec_drained", EW'(m_axis_tvalid), EW'(0));
    end

    // 4-beat packet with a mid-packet mode change, then a packet in the new mode
    cfg_mode = 2'd1;
    send_beat(rand_word(), '1, 1'b0);
    check("pkt_fsm_in_pkt", EW'(fsm_state), EW'(1));
    send_beat(rand_word(), '1, 1'b0);
    cfg_mode = 2'd0;
    send_beat(rand_word(), '1, 1'b0);
    send_beat(rand_word(), '1, 1'b1);
    check("pkt_mode_held", EW'(active_mode), EW'(1));
    send_beat(rand_word(), '1, 1'b0);
    check("next_pkt_mode", EW'(active_mode), EW'(0));
    send_beat(rand_word(), '1, 1'b1);
    drain();

    // Throughput with tready held high: one accept per cycle, one cycle to drain
    start = cyc;
    for (int i = 0; i < 20; i++) begin
      cfg_mode = 2'($urandom_range(0, 3));
      send_beat(rand_word(), '1, (i % 5) == 4);
    end
    check("tput_cycles", EW'(cyc - start), EW'(20));
    s_axis_tvalid = 1'b0;
    cycle();
    check("tput_drain_1cyc", EW'(exp_q.size()), EW'(0));

    // Randomized 100-beat stream with 50% backpressure
    rnd_ready = 1'b1;
    plen = 0;
    for (int i = 0; i < 100; i++) begin
      if (plen == 0) plen = $urandom_range(1, 5);
      cfg_mode = 2'($urandom_range(0, 3));
      plen--;
      send_beat(rand_word(), (plen == 0) ? DB'($urandom) : '1, plen == 0);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    rnd_ready = 1'b0;
    m_axis_tready = 1'b1;
    drain();

    // Reset asserted during beat 3 of a 6-beat packet
    cfg_mode = 2'd0;
    send_beat(rand_word(), '1, 1'b0);
    send_beat(rand_word(), '1, 1'b0);
    s_axis_tdata = rand_word();
    s_axis_tlast = 1'b0;
    s_axis_tvalid = 1'b1;
    reset = 1'b1;
    #2;
    check("midrst_m_valid", EW'(m_axis_tvalid), EW'(0));
    check("midrst_s_ready", EW'(s_axis_tready), EW'(0));
    @(posedge clk);
    #1;
    check("midrst_m_valid_edge", EW'(m_axis_tvalid), EW'(0));
    check("midrst_fsm", EW'(fsm_state), EW'(0));
    exp_q.delete();
    mdl_in_pkt = 1'b0;
    s_axis_tvalid = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_ready_back", EW'(s_axis_tready), EW'(1));
    cfg_mode = 2'd2;
    send_beat(rand_word(), '1, 1'b0);
    check("midrst_new_mode", EW'(active_mode), EW'(2));
    cfg_mode = 2'd1;
    send_beat(rand_word(), '1, 1'b0);
    send_beat(rand_word(), 32'h0000FFFF, 1'b1);
    drain();

`ifdef BYTE_ORDER_STATS_EN
    // Statistics: 10 packets of 3 beats, one partial keep on a first beat
    stat_clear = 1'b1;
    @(posedge clk);
    #1;
    stat_clear = 1'b0;
    check("stat_pre_pkts", EW'(stat_pkts), EW'(0));
    for (int p = 0; p < 10; p++) begin
      cfg_mode = 2'($urandom_range(0, 3));
      send_beat(rand_word(), (p == 4) ? 32'h0000000F : '1, 1'b0);
      send_beat(rand_word(), '1, 1'b0);
      send_beat(rand_word(), '1, 1'b1);
    end
    drain();
    check("stat_pkts", EW'(stat_pkts), EW'(10));
    check("stat_beats", EW'(stat_beats), EW'(30));
    check("stat_keep_err", EW'(stat_keep_err), EW'(1));
    stat_clear = 1'b1;
    @(posedge clk);
    #1;
    stat_clear = 1'b0;
    check("stat_clr_pkts", EW'(stat_pkts), EW'(0));
    check("stat_clr_beats", EW'(stat_beats), EW'(0));
    check("stat_clr_keep_err", EW'(stat_keep_err), EW'(0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
